// File: rtl/inst_mem_prefetch.sv
// Instruction memory with a prefetch queue and redirect/fault handling.
// Optional write port is enabled with `define INST_MEM_WR_PORT_EN.
module inst_mem_prefetch #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] Instruction_Code,
    output logic [31:0] instr_pc,
    output logic        fetch_fault
`ifdef INST_MEM_WR_PORT_EN
    ,
    input  logic        mem_we,
    input  logic [31:0] mem_waddr,
    input  logic [31:0] mem_wdata
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 2;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW:0]   CNT_ONE = {{PW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {RUN, HOLD, FAULT} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, fetch_pc_nxt;
    logic [31:0]   iss_pc;
    logic [AW-1:0] iss_idx;
    logic          iss_bad;
    logic          issue;
    logic          credit_ok;

    logic          s1_valid;
    logic          s1_fault;
    logic [31:0]   s1_pc;
    logic [31:0]   s1_word;

    logic [31:0]   mem [DEPTH];

    logic [31:0]   fifo_pc    [FIFO_DEPTH];
    logic [31:0]   fifo_word  [FIFO_DEPTH];
    logic          fifo_fault [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          push, pop;

    function automatic logic [31:0] boot_word(input int unsigned i);
        case (i)
            0:       boot_word = 32'h0094_0333;
            1:       boot_word = 32'h4139_03b3;
            2:       boot_word = 32'h035a_02b3;
            3:       boot_word = 32'h017b_4e33;
            4:       boot_word = 32'h019c_1eb3;
            5:       boot_word = 32'h01bd_5f33;
            6:       boot_word = 32'h00d6_7fb3;
            7:       boot_word = 32'h00f7_68b3;
            default: boot_word = NOP_WORD;
        endcase
    endfunction

`ifdef INST_MEM_WR_PORT_EN
    logic          wr_ok;
    logic [AW-1:0] wr_idx;
    assign wr_ok  = mem_we && (mem_waddr[1:0] == 2'b00) && (mem_waddr[31:AW+2] == '0);
    assign wr_idx = mem_waddr[AW+1:2];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i[AW-1:0]] <= boot_word(i);
        end
`ifdef INST_MEM_WR_PORT_EN
        else if (wr_ok) begin
            mem[wr_idx] <= mem_wdata;
        end
`endif
    end

    assign credit_ok = (CW'(count) + CW'(s1_valid)) < CW'(FIFO_DEPTH);
    assign iss_pc    = redirect ? redirect_pc : fetch_pc;
    assign iss_idx   = iss_pc[AW+1:2];
    assign iss_bad   = (iss_pc[1:0] != 2'b00) || (iss_pc[31:AW+2] != '0);

    // A redirect issues its own target in the same cycle so the target can
    // reach the head two cycles later; fetch_pc then continues past it.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        issue        = 1'b0;
        if (redirect) begin
            state_nxt    = RUN;
            fetch_pc_nxt = redirect_pc;
            if (fetch_en) begin
                issue        = 1'b1;
                fetch_pc_nxt = redirect_pc + 32'd4;
                if (iss_bad) state_nxt = FAULT;
            end
        end else begin
            case (state)
                RUN, HOLD: begin
                    if (fetch_en && credit_ok) begin
                        issue        = 1'b1;
                        fetch_pc_nxt = fetch_pc + 32'd4;
                        state_nxt    = iss_bad ? FAULT : RUN;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
                default: state_nxt = FAULT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            s1_valid <= 1'b0;
            s1_fault <= 1'b0;
            s1_pc    <= '0;
            s1_word  <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            s1_valid <= issue;
            if (issue) begin
                s1_pc    <= iss_pc;
                s1_fault <= iss_bad;
                s1_word  <= iss_bad ? NOP_WORD : mem[iss_idx];
            end
        end
    end

    assign push = s1_valid && !redirect;
    assign pop  = instr_valid && instr_ready && !redirect;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= s1_pc;
            fifo_word[wr_ptr]  <= s1_word;
            fifo_fault[wr_ptr] <= s1_fault;
        end
    end

    assign instr_valid      = (count != '0);
    assign Instruction_Code = instr_valid ? fifo_word[rd_ptr]  : '0;
    assign instr_pc         = instr_valid ? fifo_pc[rd_ptr]    : '0;
    assign fetch_fault      = instr_valid ? fifo_fault[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_inst_mem_prefetch.sv
// Self-checking bench for inst_mem_prefetch: queue-level reference model
// compared every cycle, plus directed literal checks.
module tb_inst_mem_prefetch;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned FD    = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] Instruction_Code;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    int n_checks = 0;
    int n_fail   = 0;

    inst_mem_prefetch #(
        .DEPTH(DEPTH),
        .FIFO_DEPTH(FD),
        .RESET_PC(RPC)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .fetch_en(fetch_en),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .Instruction_Code(Instruction_Code),
        .instr_pc(instr_pc),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: visible queue plus reads still travelling to it.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic        fault;
    } ent_t;

    logic [31:0] mmem [DEPTH];
    ent_t        mq[$];
    ent_t        pend[$];
    logic [31:0] m_pc;
    bit          m_flt;

    initial begin
        for (int i = 0; i < DEPTH; i++) mmem[i] = 32'h0000_0013;
        mmem[0] = 32'h0094_0333; mmem[1] = 32'h4139_03b3;
        mmem[2] = 32'h035a_02b3; mmem[3] = 32'h017b_4e33;
        mmem[4] = 32'h019c_1eb3; mmem[5] = 32'h01bd_5f33;
        mmem[6] = 32'h00d6_7fb3; mmem[7] = 32'h00f7_68b3;
    end

    always @(posedge clk or negedge rst_n) begin
        int   occ;
        bit   can;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            pend.delete();
            m_pc  = RPC;
            m_flt = 1'b0;
        end else begin
            occ = mq.size() + pend.size();
            if (redirect) begin
                mq.delete();
                pend.delete();
                m_pc  = redirect_pc;
                m_flt = 1'b0;
                can   = fetch_en;
            end else begin
                if (mq.size() > 0 && instr_ready) void'(mq.pop_front());
                while (pend.size() > 0) mq.push_back(pend.pop_front());
                can = fetch_en && !m_flt && (occ < FD);
            end
            if (can) begin
                e.pc    = m_pc;
                e.fault = (m_pc % 4 != 0) || (m_pc >= DEPTH * 4);
                e.word  = e.fault ? 32'h0000_0013 : mmem[m_pc / 4];
                pend.push_back(e);
                if (e.fault) m_flt = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_valid", {31'b0, instr_valid}, 32'd0);
            chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
            chk("rst_code", Instruction_Code, 32'd0);
            chk("rst_pc", instr_pc, 32'd0);
        end else if (mq.size() > 0) begin
            chk("cmp_valid", {31'b0, instr_valid}, 32'd1);
            chk("cmp_pc", instr_pc, mq[0].pc);
            chk("cmp_code", Instruction_Code, mq[0].word);
            chk("cmp_fault", {31'b0, fetch_fault}, {31'b0, mq[0].fault});
        end else begin
            chk("cmp_empty", {31'b0, instr_valid}, 32'd0);
        end
    end

    task automatic head(input string name, input logic [31:0] pc, input logic [31:0] w, input logic f);
        chk({name, "_v"}, {31'b0, instr_valid}, 32'd1);
        chk({name, "_pc"}, instr_pc, pc);
        chk({name, "_w"}, Instruction_Code, w);
        chk({name, "_f"}, {31'b0, fetch_fault}, {31'b0, f});
    endtask

    task automatic redir(input logic [31:0] pc, input logic rdy);
        redirect    = 1'b1;
        redirect_pc = pc;
        instr_ready = rdy;
        @(negedge clk);
        redirect = 1'b0;
    endtask

    initial begin
        logic [31:0] words [8];
        words = '{32'h0094_0333, 32'h4139_03b3, 32'h035a_02b3, 32'h017b_4e33,
                  32'h019c_1eb3, 32'h01bd_5f33, 32'h00d6_7fb3, 32'h00f7_68b3};
        rst_n       = 1'b0;
        fetch_en    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", {31'b0, instr_valid}, 32'd0);

        // Sequential fetch from reset
        rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
        @(negedge clk);
        chk("first_empty", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            head("seq", 32'(i * 4), (i < 8) ? words[i] : 32'h0000_0013, 1'b0);
            @(negedge clk);
        end

        // Backpressure fills the queue, then drains in order
        redir(32'h0, 1'b0);
        repeat (10) @(negedge clk);
        head("stall", 32'h0, 32'h0094_0333, 1'b0);
        instr_ready = 1'b1;
        @(negedge clk);
        head("drain1", 32'h4, 32'h4139_03b3, 1'b0);
        repeat (12) @(negedge clk);

        // Redirect while full
        instr_ready = 1'b0;
        repeat (6) @(negedge clk);
        redir(32'h14, 1'b1);
        chk("redir_gap", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        head("redir_t", 32'h14, 32'h01bd_5f33, 1'b0);
        @(negedge clk);
        head("redir_n", 32'h18, 32'h00d6_7fb3, 1'b0);

        // Misaligned redirect faults until redirected away
        redir(32'h6, 1'b0);
        chk("mis_gap", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        head("mis", 32'h6, 32'h0000_0013, 1'b1);
        repeat (5) @(negedge clk);
        head("mis_hold", 32'h6, 32'h0000_0013, 1'b1);
        redir(32'h0, 1'b1);
        @(negedge clk);
        head("mis_rec", 32'h0, 32'h0094_0333, 1'b0);

        // Run off the end of memory
        redir(32'(DEPTH * 4 - 8), 1'b1);
        @(negedge clk);
        head("end0", 32'(DEPTH * 4 - 8), 32'h0000_0013, 1'b0);
        @(negedge clk);
        head("end1", 32'(DEPTH * 4 - 4), 32'h0000_0013, 1'b0);
        @(negedge clk);
        head("end_flt", 32'(DEPTH * 4), 32'h0000_0013, 1'b1);
        repeat (4) @(negedge clk);
        chk("end_stop", {31'b0, instr_valid}, 32'd0);

        // fetch_en gating with irregular consumer
        fetch_en = 1'b0;
        redir(32'h10, 1'b1);
        repeat (3) @(negedge clk);
        chk("fe_off", {31'b0, instr_valid}, 32'd0);
        for (int i = 0; i < 24; i++) begin
            fetch_en    = (i % 5 != 4);
            instr_ready = (i % 3 != 0);
            @(negedge clk);
        end
        fetch_en = 1'b1; instr_ready = 1'b1;
        repeat (4) @(negedge clk);

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, instr_valid}, 32'd0);
        chk("arst_code", Instruction_Code, 32'd0);
        chk("arst_pc", instr_pc, 32'd0);
        chk("arst_fault", {31'b0, fetch_fault}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        head("restart", RPC, 32'h0094_0333, 1'b0);
        @(negedge clk);
        head("restart1", RPC + 32'd4, 32'h4139_03b3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_mem_prefetch.md
INST_MEM_PREFETCH -- requirements
Module: inst_mem_prefetch

Interface
REQ-001 Parameter DEPTH, default 64; instruction words in memory, power of two, at least 8.
REQ-002 Parameter FIFO_DEPTH, default 4; prefetch queue entries, power of two, at least 2.
REQ-003 Parameter RESET_PC, default 32'h0000_0000; first fetch address after reset.
REQ-004 Port clk, input, 1; the single clock, rising edge.
REQ-005 Port reset, input, 1; asynchronous, active-low reset.
REQ-006 Port fetch_en, input, 1; high allows new memory reads to issue.
REQ-007 Port redirect, input, 1; one-cycle pulse that loads redirect_pc as the new fetch address.
REQ-008 Port redirect_pc, input, 32; target byte address for the redirect.
REQ-009 Port instr_valid, output, 1; queue head holds a valid instruction.
REQ-010 Port instr_ready, input, 1; consumer accepts the head.
REQ-011 Port Instruction_Code, output, 32; head instruction word.
REQ-012 Port instr_pc, output, 32; byte address of the head instruction.
REQ-013 Port fetch_fault, output, 1; the head is a fault token.

Function
REQ-014 Memory SHALL be DEPTH x 32 with a synchronous read: address issued in cycle N, data written into the queue at the end of cycle N+1.
REQ-015 Word index SHALL be pc[log2(DEPTH)+1:2].
REQ-016 FSM SHALL have three states: RUN, HOLD, FAULT.
REQ-017 RUN SHALL issue one read per cycle when fetch_en=1 and (queue count + in-flight) < FIFO_DEPTH; fetch_pc SHALL then advance by 4.
REQ-018 RUN SHALL move to HOLD when the credit check fails or fetch_en=0, and HOLD SHALL return to RUN in the first cycle both conditions allow an issue.
REQ-019 The queue SHALL be first-in first-out, and each entry SHALL hold {pc, word, fault}.
REQ-020 Outputs instr_valid, Instruction_Code, instr_pc and fetch_fault SHALL be driven combinationally from the queue head.
REQ-021 A pop SHALL occur when instr_valid=1 and instr_ready=1.
REQ-022 A push and a pop in the same cycle SHALL leave the count unchanged, including when the queue is full.
REQ-023 The queue SHALL never overflow: issue credit guarantees space for every in-flight read.
REQ-024 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 While instr_valid=1 and instr_ready=0, all head outputs SHALL stay stable.
REQ-026 A redirect in cycle N SHALL flush the queue, cancel any in-flight read and set fetch_pc=redirect_pc.
REQ-027 After a redirect in cycle N, instr_valid SHALL be 0 in cycle N+1, and the redirect target SHALL be at the head in cycle N+2 if fetch_en=1.
REQ-028 Redirect SHALL take priority over a simultaneous pop, push or issue, and a head accepted in the redirect cycle SHALL count as consumed.
REQ-029 A fetch address with pc[1:0]!=0 or pc >= DEPTH*4 SHALL NOT read memory and SHALL instead push a fault token {pc, 32'h0000_0013, 1}, then enter FAULT.
REQ-030 FAULT SHALL issue nothing further, and only redirect or reset SHALL leave it, going to RUN.

Reset
REQ-031 Reset assertion SHALL take effect immediately regardless of clk, including mid-fetch or mid-handshake.
REQ-032 During reset: instr_valid=0, fetch_fault=0, Instruction_Code=0, instr_pc=0, queue empty, in-flight cleared, state=RUN, fetch_pc=RESET_PC.
REQ-033 During reset, memory words 0..7 SHALL load 00940333, 413903b3, 035a02b3, 017b4e33, 019c1eb3, 01bd5f33, 00d67fb3, 00f768b3, and all remaining words SHALL load 00000013.
REQ-034 The first read SHALL issue in the first rising edge after deassertion when fetch_en=1.

Configuration
REQ-035 With INST_MEM_WR_PORT_EN defined, the block SHALL add three inputs: mem_we (1 bit), mem_waddr (32 bits, byte address), mem_wdata (32 bits).
REQ-036 With INST_MEM_WR_PORT_EN defined, a write SHALL occur at the clock edge and a same-cycle read of the same word SHALL return the old data.
REQ-037 With INST_MEM_WR_PORT_EN defined, a misaligned or out-of-range write SHALL be ignored.
REQ-038 Without INST_MEM_WR_PORT_EN, these ports SHALL be absent and the memory SHALL be read-only after reset.

Verification
REQ-039 Reset, then fetch_en=1 and instr_ready=1 held: heads are PC 0,4,...,28 with words 00940333 ... 00f768b3 at one per cycle, and PC 32 is 00000013.
REQ-040 instr_ready=0 for 10 cycles: the queue fills to FIFO_DEPTH with no more issues, the head stays PC 0 / 00940333, and after release the words arrive in order with none lost or duplicated.
REQ-041 Redirect to 0x14 while the queue is full: instr_valid=0 in cycle N+1, then PC 0x14 / 01bd5f33 in cycle N+2, followed by 0x18 / 00d67fb3.
REQ-042 Redirect to 0x6: fault head with pc 0x6, word 00000013 and fetch_fault=1 that persists until a redirect to 0x0, after which normal fetch resumes.
REQ-043 Sequential fetch reaching DEPTH*4: a fault token appears at pc DEPTH*4 and issue stops.
REQ-044 Reset asserted mid-stream between clock edges: outputs clear immediately, and after deassertion fetch restarts at RESET_PC.
